// File: rtl/alu_addsub_responder.sv
// Handshaked 4-bit signed add/subtract responder with an in-order result buffer.
// Requests are computed on acceptance and stored; responses pop from the buffer head.
module alu_addsub_responder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  input  logic                   req_cin,
  input  logic                   req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_cout,
  output logic                   rsp_ovf,
  output logic                   rsp_zero,
  output logic                   rsp_neg,
  output logic [$clog2(DEPTH):0] rsp_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [EW-1:0]   r_mem [DEPTH];

  logic            w_push, w_pop;
  logic [WIDTH-1:0] w_b_x;
  logic            w_cin_x;
  logic [WIDTH:0]  w_sum;
  logic            w_ovf;
  logic [EW-1:0]   w_head;

  // Subtraction reuses the adder: a + ~b + ~cin == a - b - cin
  assign w_b_x   = req_sub ? ~req_b : req_b;
  assign w_cin_x = req_sub ? ~req_cin : req_cin;
  assign w_sum   = {1'b0, req_a} + {1'b0, w_b_x} + (WIDTH+1)'(w_cin_x);
  assign w_ovf   = (req_a[WIDTH-1] == w_b_x[WIDTH-1]) &
                   (w_sum[WIDTH-1] != req_a[WIDTH-1]);

  assign rsp_valid = (r_state != ST_EMPTY);
  assign w_pop     = rsp_valid & rsp_ready;
  assign req_ready = (r_state != ST_FULL) | w_pop;
  assign w_push    = req_valid & req_ready;
  assign rsp_count = r_count;

  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_count_nxt == '0)
      w_state_nxt = ST_EMPTY;
    else if (w_count_nxt == CW'(DEPTH))
      w_state_nxt = ST_FULL;
    else
      w_state_nxt = ST_PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_sum, w_ovf};
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Entry layout {cout, result, ovf}; outputs forced to zero while empty so
  // memory contents left over from before a reset never appear.
  assign w_head     = r_mem[r_rd_ptr];
  assign rsp_result = rsp_valid ? w_head[WIDTH:1] : '0;
  assign rsp_cout   = rsp_valid & w_head[WIDTH+1];
  assign rsp_ovf    = rsp_valid & w_head[0];
  assign rsp_zero   = rsp_valid & (rsp_result == '0);
  assign rsp_neg    = rsp_result[WIDTH-1];

endmodule
